// File: rtl/descriptor_receive_pkg.sv
// Shared definitions for the descriptor write/ack handshake between the senders and this receiver.
// The sender holds wr with stable data until it samples ack, and drops wr on the cycle after the ack cycle.
package descriptor_receive_pkg;

    localparam int unsigned DESC_W         = 72;
    localparam int unsigned DESC_BUFID_LSB = 0;
    localparam int unsigned DESC_BUFID_MSB = 8;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } channel_e;

endpackage

// File: rtl/descriptor_fifo_sync.sv
// Synchronous show-ahead FIFO with register storage; the head reads as zero while empty.
module descriptor_fifo_sync #(
    parameter int unsigned DW    = 72,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] iv_data,
    input  logic          i_pop,
    output logic [DW-1:0] ov_data,
    output logic [AW:0]   ov_usedw,
    output logic          o_empty,
    output logic          o_full
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   usedw;
    logic          do_push;
    logic          do_pop;

    assign o_empty  = (usedw == '0);
    assign o_full   = (usedw == (AW+1)'(DEPTH));
    assign do_push  = i_push & ~o_full;
    assign do_pop   = i_pop & ~o_empty;
    assign ov_usedw = usedw;
    assign ov_data  = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= iv_data;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   usedw <= usedw + (AW+1)'(1);
                2'b01:   usedw <= usedw - (AW+1)'(1);
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/descriptor_receive.sv
// Round-robin receiver for two descriptor senders: one-cycle registered ack, FIFO buffering and accept counters.
module descriptor_receive
    import descriptor_receive_pkg::*;
#(
    parameter int unsigned DW    = DESC_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned CW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_descriptor_wr_0,
    input  logic [DW-1:0] iv_descriptor_0,
    output logic          o_descriptor_ack_0,
    input  logic          i_descriptor_wr_1,
    input  logic [DW-1:0] iv_descriptor_1,
    output logic          o_descriptor_ack_1,
    output logic          o_descriptor_wr,
    output logic [DW-1:0] ov_descriptor,
    input  logic          i_descriptor_ready,
    output logic [AW:0]   ov_fifo_usedw,
    output logic [CW-1:0] ov_des_cnt_0,
    output logic [CW-1:0] ov_des_cnt_1
);

    channel_e      last_grant;
    logic          ack0_q;
    logic          ack1_q;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;
    logic          elig0;
    logic          elig1;
    logic          grant0;
    logic          grant1;
    logic          fifo_full;
    logic          fifo_empty;

    // A channel whose ack is currently high still shows wr; that cycle is the tail of the previous transfer.
    always_comb begin
        elig0  = i_descriptor_wr_0 & ~ack0_q;
        elig1  = i_descriptor_wr_1 & ~ack1_q;
        grant0 = ~fifo_full & elig0 & (~elig1 | (last_grant == CH1));
        grant1 = ~fifo_full & elig1 & (~elig0 | (last_grant == CH0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            last_grant <= CH1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            ack0_q <= grant0;
            ack1_q <= grant1;
            if (grant0) begin
                last_grant <= CH0;
                cnt0_q     <= cnt0_q + CW'(1);
            end else if (grant1) begin
                last_grant <= CH1;
                cnt1_q     <= cnt1_q + CW'(1);
            end
        end
    end

    descriptor_fifo_sync #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (grant0 | grant1),
        .iv_data  (grant0 ? iv_descriptor_0 : iv_descriptor_1),
        .i_pop    (o_descriptor_wr & i_descriptor_ready),
        .ov_data  (ov_descriptor),
        .ov_usedw (ov_fifo_usedw),
        .o_empty  (fifo_empty),
        .o_full   (fifo_full)
    );

    assign o_descriptor_wr    = ~fifo_empty;
    assign o_descriptor_ack_0 = ack0_q;
    assign o_descriptor_ack_1 = ack1_q;
    assign ov_des_cnt_0       = cnt0_q;
    assign ov_des_cnt_1       = cnt1_q;

endmodule

// File: tb/tb_descriptor_receive.sv
// Directed bench with sender models and a scoreboard of accepted descriptors in acceptance order.
module tb_descriptor_receive;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [71:0] d0 = '0, d1 = '0;
    logic        ack0, ack1, o_wr, ready = 1'b0;
    logic [71:0] ov_desc;
    logic [2:0]  usedw;
    logic [15:0] cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;
    logic [71:0] expq[$];
    logic [71:0] pend0[$];
    logic [71:0] pend1[$];
    int          chlog[$];
    logic        saw0 = 1'b0, saw1 = 1'b0;
    logic [15:0] cnt0_m = '0, cnt1_m = '0;

    always #5 i_clk = ~i_clk;

    descriptor_receive #(
        .DW    (72),
        .DEPTH (4),
        .AW    (2),
        .CW    (16)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_descriptor_wr_0  (wr0),
        .iv_descriptor_0    (d0),
        .o_descriptor_ack_0 (ack0),
        .i_descriptor_wr_1  (wr1),
        .iv_descriptor_1    (d1),
        .o_descriptor_ack_1 (ack1),
        .o_descriptor_wr    (o_wr),
        .ov_descriptor      (ov_desc),
        .i_descriptor_ready (ready),
        .ov_fifo_usedw      (usedw),
        .ov_des_cnt_0       (cnt0),
        .ov_des_cnt_1       (cnt1)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic kick();
        if (!wr0 && !saw0 && pend0.size() > 0) begin d0 = pend0.pop_front(); wr0 = 1'b1; end
        if (!wr1 && !saw1 && pend1.size() > 0) begin d1 = pend1.pop_front(); wr1 = 1'b1; end
    endtask

    // One clock: advance sender models on observed acks, then compare every output against the scoreboard.
    task automatic step();
        logic pop, old_saw0, old_saw1;
        pop = o_wr & ready;
        @(posedge i_clk); #1;
        if (pop && expq.size() > 0) void'(expq.pop_front());
        old_saw0 = saw0;
        old_saw1 = saw1;
        saw0 = 1'b0;
        saw1 = 1'b0;
        chk("ack_exclusive", 72'(ack0 & ack1), 72'd0);
        if (ack0) begin
            chk("ack0_legal", 72'(wr0 & ~old_saw0), 72'd1);
            expq.push_back(d0); cnt0_m++; saw0 = 1'b1; chlog.push_back(0);
        end
        if (ack1) begin
            chk("ack1_legal", 72'(wr1 & ~old_saw1), 72'd1);
            expq.push_back(d1); cnt1_m++; saw1 = 1'b1; chlog.push_back(1);
        end
        if (old_saw0) begin
            if (pend0.size() > 0) d0 = pend0.pop_front(); else wr0 = 1'b0;
        end
        if (old_saw1) begin
            if (pend1.size() > 0) d1 = pend1.pop_front(); else wr1 = 1'b0;
        end
        chk("usedw", 72'(usedw), 72'(expq.size()));
        chk("usedw_max", 72'(usedw <= 3'd4), 72'd1);
        chk("o_wr", 72'(o_wr), 72'(expq.size() != 0));
        chk("head", ov_desc, (expq.size() != 0) ? expq[0] : 72'd0);
        chk("cnt0", 72'(cnt0), 72'(cnt0_m));
        chk("cnt1", 72'(cnt1), 72'(cnt1_m));
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        while ((wr0 || wr1 || saw0 || saw1 || pend0.size() > 0 || pend1.size() > 0 || expq.size() > 0) && n < 300) begin
            step(); kick(); n++;
        end
        chk(tag, 72'(n < 300), 72'd1);
    endtask

    initial begin
        logic [71:0] single;
        int n;
        int exp_ch[6] = '{0, 1, 0, 1, 0, 1};

        // reset state
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_ack0", 72'(ack0), 72'd0);
        chk("rst_ack1", 72'(ack1), 72'd0);
        chk("rst_owr", 72'(o_wr), 72'd0);
        chk("rst_desc", ov_desc, 72'd0);
        chk("rst_usedw", 72'(usedw), 72'd0);
        i_rst = 1'b0;

        // contention: both channels from the same cycle, ch0 first after reset
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pend0.push_back(72'h100 + 72'(i));
            pend1.push_back(72'h200 + 72'(i));
        end
        kick();
        run_until_idle("contention_done");
        chk("contention_count", 72'(chlog.size()), 72'd6);
        for (int i = 0; i < 6; i++) begin
            chk("contention_order", 72'((i < chlog.size()) ? chlog[i] : -1), 72'(exp_ch[i]));
        end

        // single transfer, no second accept during the ack cycle
        ready = 1'b0;
        single = 72'h0A_BCDE_F012_3456_7105;
        d0 = single; wr0 = 1'b1;
        step();
        chk("single_ack0", 72'(ack0), 72'd1);
        chk("single_owr", 72'(o_wr), 72'd1);
        chk("single_desc", ov_desc, single);
        chk("single_cnt0", 72'(cnt0), 72'd4);
        step();
        chk("single_ack0_off", 72'(ack0), 72'd0);
        chk("single_usedw", 72'(usedw), 72'd1);
        step();
        chk("single_usedw_hold", 72'(usedw), 72'd1);
        ready = 1'b1;
        run_until_idle("single_drain");

        // full FIFO back-pressure
        ready = 1'b0;
        for (int i = 0; i < 5; i++) pend0.push_back(72'hF00 + 72'(i));
        kick();
        n = 0;
        while (expq.size() < 4 && n < 50) begin step(); kick(); n++; end
        chk("full_fill", 72'(n < 50), 72'd1);
        repeat (6) step();
        chk("full_usedw", 72'(usedw), 72'd4);
        chk("full_wr_held", 72'(wr0), 72'd1);
        chk("full_no_ack", 72'(ack0), 72'd0);
        chk("full_pending_data", d0, 72'hF04);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("full_pop_usedw", 72'(usedw), 72'd3);
        chk("full_pop_no_ack", 72'(ack0), 72'd0);
        step();
        chk("full_fifth_ack", 72'(ack0), 72'd1);
        chk("full_refill_usedw", 72'(usedw), 72'd4);
        ready = 1'b1;
        run_until_idle("full_drain");

        // pointer wrap with ready toggling
        for (int i = 0; i < 5; i++) begin
            pend0.push_back(72'hA0_0000_0000_0000_0000 + 72'(i));
            pend1.push_back(72'hB0_0000_0000_0000_0000 + 72'(i));
        end
        kick();
        n = 0;
        while ((wr0 || wr1 || saw0 || saw1 || pend0.size() > 0 || pend1.size() > 0 || expq.size() > 0) && n < 300) begin
            ready = ~ready;
            step(); kick(); n++;
        end
        chk("wrap_done", 72'(n < 300), 72'd1);
        ready = 1'b1;

        // counter wrap on channel 1
        force dut.cnt1_q = 16'hFFFF;
        @(posedge i_clk); #1;
        release dut.cnt1_q;
        cnt1_m = 16'hFFFF;
        @(posedge i_clk); #1;
        chk("cnt1_preset", 72'(cnt1), 72'h0FFFF);
        pend1.push_back(72'h1FF);
        kick();
        run_until_idle("cntwrap_done");
        chk("cnt1_wrapped", 72'(cnt1), 72'd0);

        // reset mid-operation
        ready = 1'b0;
        pend0.push_back(72'hC1);
        pend0.push_back(72'hC2);
        kick();
        n = 0;
        while ((expq.size() < 2 || wr0 || saw0) && n < 50) begin step(); kick(); n++; end
        chk("rstmid_fill", 72'(n < 50), 72'd1);
        d1 = 72'hD1; wr1 = 1'b1;
        d0 = 72'hE1; wr0 = 1'b1;
        step();
        chk("rstmid_ack1", 72'(ack1), 72'd1);
        chk("rstmid_usedw3", 72'(usedw), 72'd3);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("rstmid_ack0", 72'(ack0), 72'd0);
        chk("rstmid_ack1_lost", 72'(ack1), 72'd0);
        chk("rstmid_owr", 72'(o_wr), 72'd0);
        chk("rstmid_desc", ov_desc, 72'd0);
        chk("rstmid_usedw", 72'(usedw), 72'd0);
        chk("rstmid_cnt0", 72'(cnt0), 72'd0);
        chk("rstmid_cnt1", 72'(cnt1), 72'd0);
        expq.delete();
        cnt0_m = '0; cnt1_m = '0;
        saw0 = 1'b0; saw1 = 1'b0; wr1 = 1'b0;
        i_rst = 1'b0;
        step();
        chk("rstmid_fresh_ack0", 72'(ack0), 72'd1);
        chk("rstmid_usedw1", 72'(usedw), 72'd1);
        chk("rstmid_head", ov_desc, 72'hE1);
        ready = 1'b1;
        run_until_idle("rstmid_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/descriptor_receive.md
Name: descriptor_receive

Overview:
- Receiving end of the descriptor write/ack handshake.
- Two upstream descriptor senders (one per network input port) hold `wr` high with stable data until they sample `ack`.
- This block arbitrates round-robin between them, returns a one-cycle ack, and buffers accepted descriptors in a small FIFO.
- The FIFO presents a show-ahead valid/ready stream to the downstream lookup stage.

Parameters:
- DW, 72, descriptor width in bits; bits [8:0] carry pkt_bufid.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- AW, 2, log2(DEPTH).
- CW, 16, width of the per-channel accept counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_descriptor_wr_0  in  1  channel 0 descriptor write request, level-held until ack.
- iv_descriptor_0  in  DW  channel 0 descriptor.
- o_descriptor_ack_0  out  1  channel 0 one-cycle ack.
- i_descriptor_wr_1  in  1  channel 1 write request.
- iv_descriptor_1  in  DW  channel 1 descriptor.
- o_descriptor_ack_1  out  1  channel 1 one-cycle ack.
- o_descriptor_wr  out  1  FIFO non-empty; head descriptor valid.
- ov_descriptor  out  DW  FIFO head.
- i_descriptor_ready  in  1  downstream consumes the head this cycle.
- ov_fifo_usedw  out  AW+1  current occupancy, 0..DEPTH.
- ov_des_cnt_0  out  CW  descriptors accepted from channel 0 (wraps).
- ov_des_cnt_1  out  CW  descriptors accepted from channel 1 (wraps).

Behaviour:
- Reset: one clock, sync active-high. Every output goes to 0: acks, o_descriptor_wr, ov_descriptor, ov_fifo_usedw, counters. FIFO pointers clear. Round-robin pointer `last_grant` = 1, so channel 0 wins first.
- Eligibility: channel n is eligible when i_descriptor_wr_n=1 AND o_descriptor_ack_n=0 in the same cycle.
  - The sender drops wr one cycle after it samples ack, so wr is still high during the ack cycle.
  - That cycle must not be accepted again.
- Accept condition: at least one channel eligible AND usedw < DEPTH, evaluated on the registered usedw. A pop in the same cycle does not free a slot.
- Arbitration:
  - One eligible channel: grant it.
  - Both eligible: grant the channel ≠ last_grant.
  - last_grant updates only on a grant.
- On grant at edge t:
  - The granted descriptor is written unmodified to the FIFO tail.
  - o_descriptor_ack_n = 1 for exactly cycle t+1, registered. The other ack stays 0.
  - ov_des_cnt_n increments modulo 2^CW.
- Full FIFO: no grant and no ack. The senders keep holding wr; nothing is dropped.
- Output side (show-ahead):
  - o_descriptor_wr = (usedw ≠ 0).
  - ov_descriptor = head entry, registered. When empty it is forced to 0.
  - Pop when o_descriptor_wr & i_descriptor_ready. The next head or 0 appears the following cycle.
- Latency: input wr first high in cycle t with FIFO empty → ack and o_descriptor_wr both high in t+1, ov_descriptor valid in t+1.
- Simultaneous push and pop: usedw unchanged; pointers both advance and wrap modulo DEPTH.
- Throughput:
  - One accept per channel every 2 cycles, because of the ack cycle.
  - With both channels active, the block alternates and sustains 1 accept per cycle.
- Ready while empty: ignored.
- Reset mid-operation: FIFO contents are discarded and any pending ack is lost. A sender still holding wr after reset is accepted again, so a duplicate is possible. Upstream must be reset together with this block.
- No other state machine: per-channel state is implicit in ack/wr. The FSM-free design is intentional.

Decomposition:
- Shared package holds:
  - DESC_W=72.
  - DESC_BUFID_LSB=0, DESC_BUFID_MSB=8.
  - Handshake notes shared with the sender.
- Sub-module descriptor_fifo_sync: synchronous, show-ahead, DEPTH×DW register-based storage with push/pop/usedw/empty/full.
- Arbitration, ack generation and counters live in the top.

Test Plan:
- Single: ch0 wr=1 with data 72'h0A_BCDE_F012_3456_7105, held until ack → ack_0 high one cycle at t+1, o_descriptor_wr=1, ov_descriptor equals data, ov_des_cnt_0=1, no second entry while wr is still high during the ack cycle.
- Contention: both channels hold wr from cycle 0 with ready=1 → grants alternate 0,1,0,1, acks never coincide, FIFO output order matches the grants.
- Full: ready=0, 5 descriptors offered on ch0 → 4 acks, usedw=4, 5th wr held with no ack. Then ready=1 for one cycle → pop; 5th ack arrives one cycle later (accepted the cycle after usedw drops), usedw returns to 4.
- Wrap: 10 descriptors through with ready toggling 1/0 → output order intact across pointer wrap, usedw never exceeds 4, ov_descriptor=0 whenever empty.
- Counter wrap: force ov_des_cnt_1 to 16'hFFFF, accept one ch1 descriptor → counter reads 16'h0000.
- Reset mid-op: usedw=3 and ack_1 high, assert i_rst one cycle → all outputs 0 next cycle. With ch0 wr held, after deassert a fresh ack_0 arrives and usedw=1.
